jpeg_mcu_scheduler: RTL and testbench

- Sequences a single shared 8x8-block datapath (quantize/encode cone) between three component streams: Y, Cb and Cr.
- Enforces MCU order: Y_BLKS luma blocks, then one Cb block, then one Cr block.
- Streams COEF_PER_BLK coefficient beats per block using a valid/ready handshake.
- Waits for the datapath's completion pulse before advancing to the next slot, and reports MCU progress.

---
 rtl/jpeg_mcu_scheduler_if.sv | 19 +
 rtl/jpeg_mcu_scheduler.sv | 65 ++++++
 tb/tb_jpeg_mcu_scheduler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_mcu_scheduler_if.sv
// jpeg_mcu_scheduler_if: handshake/status bundle between the MCU scheduler and its sources and datapath
//   master (scheduler): drives readies, dp_valid, comp_sel, blk_first/last, mcu_done, busy, mcu_count
//   slave (environment): drives enable, y/cb/cr_valid, dp_ready, dp_done
interface jpeg_mcu_scheduler_if #(
   parameter int CNT_W = 16
);
   logic             enable, y_valid, cb_valid, cr_valid, dp_ready, dp_done;
   logic             y_ready, cb_ready, cr_ready, dp_valid, blk_first, blk_last, mcu_done, busy;
   logic [1:0]       comp_sel;
   logic [CNT_W-1:0] mcu_count;
   modport master (
      input  enable, y_valid, cb_valid, cr_valid, dp_ready, dp_done,
      output y_ready, cb_ready, cr_ready, dp_valid, blk_first, blk_last, mcu_done, busy, comp_sel, mcu_count
   );
   modport slave (
      output enable, y_valid, cb_valid, cr_valid, dp_ready, dp_done,
      input  y_ready, cb_ready, cr_ready, dp_valid, blk_first, blk_last, mcu_done, busy, comp_sel, mcu_count
   );
endinterface

// File: rtl/jpeg_mcu_scheduler.sv
// jpeg_mcu_scheduler: sequences Y_BLKS luma, one Cb and one Cr block per MCU through a shared 8x8 datapath
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : master side of jpeg_mcu_scheduler_if (source valid/ready, datapath handshake, MCU status)
module jpeg_mcu_scheduler #(
   parameter int COEF_PER_BLK = 64,
   parameter int Y_BLKS       = 4,
   parameter int CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   jpeg_mcu_scheduler_if.master bus
);
   localparam int CW = $clog2(COEF_PER_BLK);
   typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;
   state_t           state_q;
   logic [2:0]       slot_q, slot_d;
   logic [1:0]       comp_q, comp_d;
   logic [CW-1:0]    coef_q;
   logic [CNT_W-1:0] mcu_q;
   logic             stream, sel_valid, beat, done_blk;
   always_comb begin
      stream    = state_q == STREAM;
      sel_valid = comp_q == 2'd0 ? bus.y_valid : comp_q == 2'd1 ? bus.cb_valid : bus.cr_valid;
      beat      = stream && sel_valid && bus.dp_ready;
      done_blk  = state_q == WAIT_DONE && bus.dp_done;
      slot_d    = slot_q == 3'(Y_BLKS + 1) ? 3'd0 : slot_q + 3'd1;
      comp_d    = slot_d < 3'(Y_BLKS) ? 2'd0 : slot_d == 3'(Y_BLKS) ? 2'd1 : 2'd2;
   end
   assign bus.dp_valid  = stream && sel_valid;
   assign bus.y_ready   = stream && comp_q == 2'd0 && bus.dp_ready;
   assign bus.cb_ready  = stream && comp_q == 2'd1 && bus.dp_ready;
   assign bus.cr_ready  = stream && comp_q == 2'd2 && bus.dp_ready;
   assign bus.blk_first = stream && sel_valid && coef_q == '0;
   assign bus.blk_last  = stream && sel_valid && &coef_q;
   assign bus.mcu_done  = done_blk && comp_q == 2'd2;
   assign bus.busy      = state_q != IDLE;
   assign bus.comp_sel  = comp_q;
   assign bus.mcu_count = mcu_q;
   // comp_q tracks the component of slot_q so the output mux never decodes slot combinationally;
   // the beat counter is a power-of-2 width, so the last beat wraps it back to zero by itself
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         comp_q  <= '0;
         coef_q  <= '0;
         mcu_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.enable) state_q <= STREAM;
            STREAM: if (beat) begin
               coef_q <= coef_q + 1'b1;
               if (&coef_q) state_q <= WAIT_DONE;
            end
            WAIT_DONE: if (bus.dp_done) begin
               slot_q  <= slot_d;
               comp_q  <= comp_d;
               if (comp_q == 2'd2) mcu_q <= mcu_q + 1'b1;
               state_q <= bus.enable ? STREAM : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// tb_jpeg_mcu_scheduler: directed bench for jpeg_mcu_scheduler (4:2:0, 4:4:4 and a short-counter variant)
module tb_jpeg_mcu_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, y_valid, cb_valid, cr_valid, dp_ready, dp_done;
   logic [2:0] en;
   int cur = 0;
   int total = 0;
   int bad = 0;
   jpeg_mcu_scheduler_if #(.CNT_W(16)) b0 ();
   jpeg_mcu_scheduler_if #(.CNT_W(16)) b1 ();
   jpeg_mcu_scheduler_if #(.CNT_W(2))  b2 ();
   assign b0.enable = en[0], b0.y_valid = y_valid, b0.cb_valid = cb_valid, b0.cr_valid = cr_valid, b0.dp_ready = dp_ready, b0.dp_done = dp_done;
   assign b1.enable = en[1], b1.y_valid = y_valid, b1.cb_valid = cb_valid, b1.cr_valid = cr_valid, b1.dp_ready = dp_ready, b1.dp_done = dp_done;
   assign b2.enable = en[2], b2.y_valid = y_valid, b2.cb_valid = cb_valid, b2.cr_valid = cr_valid, b2.dp_ready = dp_ready, b2.dp_done = dp_done;
   jpeg_mcu_scheduler #(.COEF_PER_BLK(64), .Y_BLKS(4), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   jpeg_mcu_scheduler #(.COEF_PER_BLK(64), .Y_BLKS(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   jpeg_mcu_scheduler #(.COEF_PER_BLK(4),  .Y_BLKS(1), .CNT_W(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   logic o_valid, o_yr, o_cbr, o_crr, o_first, o_last, o_mcu, o_busy;
   logic [1:0]  o_comp;
   logic [15:0] o_cnt;
   always_comb begin
      o_valid = cur == 0 ? b0.dp_valid  : cur == 1 ? b1.dp_valid  : b2.dp_valid;
      o_yr    = cur == 0 ? b0.y_ready   : cur == 1 ? b1.y_ready   : b2.y_ready;
      o_cbr   = cur == 0 ? b0.cb_ready  : cur == 1 ? b1.cb_ready  : b2.cb_ready;
      o_crr   = cur == 0 ? b0.cr_ready  : cur == 1 ? b1.cr_ready  : b2.cr_ready;
      o_first = cur == 0 ? b0.blk_first : cur == 1 ? b1.blk_first : b2.blk_first;
      o_last  = cur == 0 ? b0.blk_last  : cur == 1 ? b1.blk_last  : b2.blk_last;
      o_mcu   = cur == 0 ? b0.mcu_done  : cur == 1 ? b1.mcu_done  : b2.mcu_done;
      o_busy  = cur == 0 ? b0.busy      : cur == 1 ? b1.busy      : b2.busy;
      o_comp  = cur == 0 ? b0.comp_sel  : cur == 1 ? b1.comp_sel  : b2.comp_sel;
      o_cnt   = cur == 0 ? b0.mcu_count : cur == 1 ? b1.mcu_count : 16'(b2.mcu_count);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // streams one block of the selected DUT and reports what was observed; errs counts
   // ready/valid inconsistencies, component changes mid-block and misplaced first/last flags
   task automatic run_block(input int ncoef, input int drop_at, input int drop_len, input int en_off_at,
                            input int early_at, output int comp, output int beats, output int first_at,
                            output int last_at, output int nmark, output int errs);
      int stall = 0;
      bit fin = 1'b0;
      comp = -1; beats = 0; first_at = -1; last_at = -1; nmark = 0; errs = 0;
      for (int k = 0; k < 3 * ncoef + 20 && !fin; k++) begin
         dp_ready = !(drop_at >= 0 && beats >= drop_at && stall < drop_len);
         if (beats == en_off_at) en[cur] = 1'b0;
         dp_done = (beats == early_at);
         #1;
         if (o_valid) begin
            if ((o_comp == 2'd0 ? o_yr : o_comp == 2'd1 ? o_cbr : o_crr) !== dp_ready) errs++;
            if (int'(o_yr) + int'(o_cbr) + int'(o_crr) > 1) errs++;
         end else if (o_yr || o_cbr || o_crr || o_first || o_last) errs++;
         if (o_valid && dp_ready) begin
            if (comp < 0) comp = int'(o_comp);
            else if (comp != int'(o_comp)) errs++;
            if (o_first) begin first_at = beats; nmark++; end
            if (o_last) begin last_at = beats; nmark++; fin = 1'b1; end
            beats++;
         end else if ((o_first && beats != 0) || (o_last && beats != ncoef - 1)) errs++;
         if (!dp_ready) stall++;
         cyc();
      end
      dp_ready = 1'b1;
      dp_done = 1'b0;
   endtask

   task automatic finish_block(input int gap, output bit mcu);
      dp_done = 1'b0;
      repeat (gap) cyc();
      dp_done = 1'b1;
      #1;
      mcu = o_mcu;
      cyc();
      dp_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = '0; y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1; dp_ready = 1'b1; dp_done = 1'b1;
      repeat (2) cyc();
      for (int k = 0; k < 3; k++) begin
         cur = k;
         #1;
         total++; if ({o_valid, o_yr, o_cbr, o_crr, o_first, o_last, o_mcu, o_busy} !== 8'h00) begin bad++; $display("FAIL reset_outs dut%0d got=%b want=00000000", k, {o_valid, o_yr, o_cbr, o_crr, o_first, o_last, o_mcu, o_busy}); end
         total++; if (o_comp !== 2'd0) begin bad++; $display("FAIL reset_comp dut%0d got=%0d want=0", k, o_comp); end
         total++; if (o_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt dut%0d got=%0d want=0", k, o_cnt); end
      end
      cur = 0; dp_done = 1'b0; rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_mcu_order();
      int exp_c[6] = '{0, 0, 0, 0, 1, 2};
      int c, n, f, l, mk, e;
      bit m;
      en[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_block(64, -1, 0, -1, -1, c, n, f, l, mk, e);
         total++; if (c !== exp_c[i]) begin bad++; $display("FAIL order_comp blk%0d got=%0d want=%0d", i, c, exp_c[i]); end
         total++; if (n !== 64) begin bad++; $display("FAIL order_beats blk%0d got=%0d want=64", i, n); end
         total++; if (f !== 0 || l !== 63 || mk !== 2) begin bad++; $display("FAIL order_marks blk%0d first=%0d last=%0d n=%0d want=0/63/2", i, f, l, mk); end
         total++; if (e !== 0) begin bad++; $display("FAIL order_proto blk%0d errs=%0d want=0", i, e); end
         if (i == 5) en[0] = 1'b0;
         finish_block(0, m);
         total++; if (m !== (i == 5)) begin bad++; $display("FAIL order_mcu_done blk%0d got=%0d want=%0d", i, m, i == 5); end
      end
      #1;
      total++; if (o_cnt !== 16'd1) begin bad++; $display("FAIL order_count got=%0d want=1", o_cnt); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL order_idle busy=%0d want=0", o_busy); end
   endtask

   task automatic test_stall_enable();
      int da[4] = '{5, 0, 62, -1};
      int dl[4] = '{3, 2, 4, 0};
      int c, n, f, l, mk, e;
      bit m;
      en[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_block(64, da[i], dl[i], -1, -1, c, n, f, l, mk, e);
         total++; if (c !== 0 || n !== 64) begin bad++; $display("FAIL stall_blk%0d comp=%0d beats=%0d want=0/64", i, c, n); end
         total++; if (f !== 0 || l !== 63 || mk !== 2 || e !== 0) begin bad++; $display("FAIL stall_marks%0d first=%0d last=%0d n=%0d errs=%0d want=0/63/2/0", i, f, l, mk, e); end
         finish_block(2, m);
      end
      run_block(64, -1, 0, 10, -1, c, n, f, l, mk, e);
      total++; if (c !== 1 || n !== 64) begin bad++; $display("FAIL en_drop_cb comp=%0d beats=%0d want=1/64", c, n); end
      finish_block(1, m);
      #1;
      total++; if (o_busy !== 1'b0 || m !== 1'b0) begin bad++; $display("FAIL en_drop_idle busy=%0d mcu=%0d want=0/0", o_busy, m); end
      repeat (3) cyc();
      total++; if ({o_busy, o_valid} !== 2'b00) begin bad++; $display("FAIL en_drop_hold busy/valid=%b want=00", {o_busy, o_valid}); end
      en[0] = 1'b1;
      run_block(64, -1, 0, -1, -1, c, n, f, l, mk, e);
      total++; if (c !== 2) begin bad++; $display("FAIL resume_cr comp=%0d want=2", c); end
      finish_block(0, m);
      total++; if (m !== 1'b1) begin bad++; $display("FAIL resume_mcu_done got=%0d want=1", m); end
      run_block(64, -1, 0, -1, -1, c, n, f, l, mk, e);
      total++; if (c !== 0) begin bad++; $display("FAIL resume_y comp=%0d want=0", c); end
      finish_block(0, m);
      total++; if (o_cnt !== 16'd2) begin bad++; $display("FAIL resume_count got=%0d want=2", o_cnt); end
   endtask

   task automatic test_early_done();
      int c, n, f, l, mk, e;
      bit m;
      run_block(64, -1, 0, -1, 20, c, n, f, l, mk, e);
      total++; if (c !== 0 || n !== 64 || e !== 0) begin bad++; $display("FAIL early_blk comp=%0d beats=%0d errs=%0d want=0/64/0", c, n, e); end
      for (int j = 0; j < 4; j++) begin
         #1;
         total++; if ({o_busy, o_valid} !== 2'b10) begin bad++; $display("FAIL early_wait%0d busy/valid=%b want=10", j, {o_busy, o_valid}); end
         cyc();
      end
      finish_block(0, m);
      total++; if (m !== 1'b0) begin bad++; $display("FAIL early_mcu got=%0d want=0", m); end
   endtask

   task automatic test_reset_mid();
      int exp_a[6] = '{0, 0, 1, 2, 0, 0};
      int exp_b[5] = '{0, 0, 0, 0, 1};
      int c, n, f, l, mk, e;
      bit m;
      for (int i = 0; i < 6; i++) begin
         run_block(64, -1, 0, -1, -1, c, n, f, l, mk, e);
         total++; if (c !== exp_a[i]) begin bad++; $display("FAIL pre_reset_comp blk%0d got=%0d want=%0d", i, c, exp_a[i]); end
         finish_block(0, m);
      end
      total++; if (o_cnt !== 16'd3) begin bad++; $display("FAIL pre_reset_count got=%0d want=3", o_cnt); end
      n = 0;
      for (int k = 0; k < 100 && n < 30; k++) begin
         #1;
         if (o_valid && dp_ready) n++;
         cyc();
      end
      total++; if (n !== 30 || o_comp !== 2'd0) begin bad++; $display("FAIL mid_beats got=%0d comp=%0d want=30/0", n, o_comp); end
      rst_n = 1'b0;
      #1;
      cyc();
      total++; if ({o_valid, o_yr, o_cbr, o_crr, o_first, o_last, o_mcu, o_busy} !== 8'h00) begin bad++; $display("FAIL mid_reset_outs got=%b want=00000000", {o_valid, o_yr, o_cbr, o_crr, o_first, o_last, o_mcu, o_busy}); end
      total++; if (o_cnt !== 16'd0 || o_comp !== 2'd0) begin bad++; $display("FAIL mid_reset_cnt cnt=%0d comp=%0d want=0/0", o_cnt, o_comp); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_block(64, -1, 0, -1, -1, c, n, f, l, mk, e);
         total++; if (c !== exp_b[i] || f !== 0 || n !== 64) begin bad++; $display("FAIL restart_blk%0d comp=%0d first=%0d beats=%0d want=%0d/0/64", i, c, f, n, exp_b[i]); end
         if (i == 4) en[0] = 1'b0;
         finish_block(0, m);
      end
   endtask

   task automatic test_y1();
      int c, n, f, l, mk, e;
      bit m;
      cur = 1; en[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_block(64, -1, 0, -1, -1, c, n, f, l, mk, e);
         total++; if (c !== i || n !== 64) begin bad++; $display("FAIL y1_blk%0d comp=%0d beats=%0d want=%0d/64", i, c, n, i); end
         if (i == 2) en[1] = 1'b0;
         finish_block(0, m);
         total++; if (m !== (i == 2)) begin bad++; $display("FAIL y1_mcu blk%0d got=%0d want=%0d", i, m, i == 2); end
      end
      #1;
      total++; if (o_cnt !== 16'd1 || o_busy !== 1'b0) begin bad++; $display("FAIL y1_end cnt=%0d busy=%0d want=1/0", o_cnt, o_busy); end
   endtask

   task automatic test_wrap();
      int exp_n[4] = '{1, 2, 3, 0};
      int c, n, f, l, mk, e;
      bit m;
      cur = 2; en[2] = 1'b1;
      for (int u = 0; u < 4; u++) begin
         for (int b = 0; b < 3; b++) begin
            run_block(4, -1, 0, -1, -1, c, n, f, l, mk, e);
            total++; if (c !== b || n !== 4 || l !== 3) begin bad++; $display("FAIL wrap_blk%0d_%0d comp=%0d beats=%0d last=%0d want=%0d/4/3", u, b, c, n, l, b); end
            if (u == 3 && b == 2) en[2] = 1'b0;
            finish_block(0, m);
         end
         total++; if (o_cnt !== 16'(exp_n[u]) || m !== 1'b1) begin bad++; $display("FAIL wrap_count mcu%0d got=%0d mcu_done=%0d want=%0d/1", u, o_cnt, m, exp_n[u]); end
      end
   endtask

   initial begin
      test_reset();
      test_mcu_order();
      test_stall_enable();
      test_early_done();
      test_reset_mid();
      test_y1();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
